// File: rtl/serial_seq_tx.sv
// serial_seq_tx: framed serial transmitter (start, data MSB-first, opt. parity, stop).
// Ports: clk, rst_n, start/data/ready handshake in; xout, busy, done, frame_cnt out.
// Build option: define SERIAL_SEQ_TX_PARITY_EN to add an even-parity bit before stop.
// xout is registered: each edge loads the bit that belongs to the state being entered.
// ready = state is IDLE; busy = !ready; done pulses in the first IDLE cycle after STOP.
module serial_seq_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             xout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
`ifdef SERIAL_SEQ_TX_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd3;
`endif
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [BW-1:0]    bcnt_q;
  logic [BW-1:0]    bcnt_d;
  logic             xout_d;
  logic             done_d;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;

`ifdef SERIAL_SEQ_TX_PARITY_EN
  // Parity is captured at acceptance because the shift
  // register no longer holds the word by the PAR state.
  logic par_q;
  logic par_d;
`endif

  assign ready  = (state_q == S_IDLE);
  assign busy   = ~ready;
  assign accept = start & ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    xout_d  = 1'b0;
    done_d  = 1'b0;
    cnt_d   = frame_cnt;
`ifdef SERIAL_SEQ_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          sreg_d  = data;
          bcnt_d  = '0;
          xout_d  = 1'b1;
`ifdef SERIAL_SEQ_TX_PARITY_EN
          par_d   = ^data;
`endif
        end
      end
      S_START: begin
        state_d = S_DATA;
        xout_d  = sreg_q[WIDTH-1];
        sreg_d  = sreg_q << 1;
      end
      S_DATA: begin
        if (bcnt_q == LAST) begin
`ifdef SERIAL_SEQ_TX_PARITY_EN
          state_d = S_PAR;
          xout_d  = par_q;
`else
          state_d = S_STOP;
          xout_d  = 1'b0;
`endif
        end else begin
          bcnt_d = bcnt_q + BW'(1);
          xout_d = sreg_q[WIDTH-1];
          sreg_d = sreg_q << 1;
        end
      end
`ifdef SERIAL_SEQ_TX_PARITY_EN
      S_PAR: begin
        state_d = S_STOP;
        xout_d  = 1'b0;
      end
`endif
      S_STOP: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        cnt_d   = frame_cnt + CNT_W'(1);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sreg_q    <= '0;
      bcnt_q    <= '0;
      xout      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bcnt_q    <= bcnt_d;
      xout      <= xout_d;
      done      <= done_d;
      frame_cnt <= cnt_d;
    end
  end

`ifdef SERIAL_SEQ_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule

// File: tb/tb_serial_seq_tx.sv
// tb_serial_seq_tx: directed bench for serial_seq_tx (WIDTH=8, CNT_W=8).
// Follows SERIAL_SEQ_TX_PARITY_EN if defined for the build.
module tb_serial_seq_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
`ifdef SERIAL_SEQ_TX_PARITY_EN
  localparam int FL = WIDTH + 3;
`else
  localparam int FL = WIDTH + 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic             ready;
  logic             xout;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frame_cnt;

  int n_vec = 0;
  int n_err = 0;

  serial_seq_tx #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .data(data),
    .ready(ready),
    .xout(xout),
    .busy(busy),
    .done(done),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ok(input string tag, input int cnt);
    chk({tag, " xout"}, 32'(xout), 32'd0);
    chk({tag, " ready"}, 32'(ready), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " cnt"}, 32'(frame_cnt), 32'(cnt));
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic accept(input logic [WIDTH-1:0] d);
    start = 1'b1;
    data  = d;
    tick();
    start = 1'b0;
    chk("acc busy", 32'(busy), 32'd1);
  endtask

  // Hand-derived frame: 1, d[7]..d[0], (even parity), 0.
  function automatic logic exp_bit(input logic [WIDTH-1:0] d,
                                   input int i);
    if (i == 0) return 1'b1;
    if (i <= WIDTH) return d[WIDTH-i];
`ifdef SERIAL_SEQ_TX_PARITY_EN
    if (i == WIDTH + 1) return ^d;
`endif
    return 1'b0;
  endfunction

  // Starts in the start-bit cycle, ends in the done cycle.
  task automatic expect_frame(input logic [WIDTH-1:0] d,
                              input string tag,
                              input int poke);
    for (int i = 0; i < FL; i++) begin
      chk($sformatf("%s bit%0d", tag, i), 32'(xout),
          32'(exp_bit(d, i)));
      if (i == 0) chk({tag, " rdy"}, 32'(ready), 32'd0);
      if (i == poke) begin
        start = 1'b1;
        data  = '0;
      end else if (i == poke + 1) begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " drdy"}, 32'(ready), 32'd1);
    chk({tag, " dx"}, 32'(xout), 32'd0);
  endtask

  initial begin
    #2;
    idle_ok("por", 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      idle_ok("idle", 0);
    end

    accept(8'hA5);
    expect_frame(8'hA5, "a5", -1);
    chk("a5 cnt", 32'(frame_cnt), 32'd1);
    tick();
    chk("a5 done off", 32'(done), 32'd0);
    idle_ok("a5 post", 1);

    do_reset();
    accept(8'h07);
    expect_frame(8'h07, "b2b1", -1);
    accept(8'hFF);
    expect_frame(8'hFF, "b2b2", -1);
    chk("b2b cnt", 32'(frame_cnt), 32'd2);
    tick();
    chk("b2b done off", 32'(done), 32'd0);

    do_reset();
    accept(8'hA5);
    expect_frame(8'hA5, "ign", 3);
    tick();
    idle_ok("ign q1", 1);
    tick();
    idle_ok("ign q2", 1);

    do_reset();
    accept(8'hFF);
    for (int i = 0; i < 4; i++) tick();
    chk("mid xout", 32'(xout), 32'd1);
    rst_n = 1'b0;
    #1;
    idle_ok("mid rst", 0);
    tick();
    idle_ok("mid hold", 0);
    rst_n = 1'b1;
    tick();
    idle_ok("mid rel", 0);
    accept(8'h3C);
    expect_frame(8'h3C, "3c", -1);
    chk("3c cnt", 32'(frame_cnt), 32'd1);

    do_reset();
    for (int k = 1; k <= 256; k++) begin
      accept(k[WIDTH-1:0]);
      for (int i = 0; i < FL; i++) tick();
      chk("wrap done", 32'(done), 32'd1);
      if (k == 255) chk("wrap 255", 32'(frame_cnt), 32'd255);
      if (k == 256) chk("wrap 0", 32'(frame_cnt), 32'd0);
    end
    tick();
    chk("wrap done off", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
